rtc_bcd_timekeeper: RTL and testbench

//  Time-of-day counter that consumes the ~1 Hz single-cycle tick from the pulse generator.

---
 rtl/rtc_bcd_timekeeper.sv | 120 ++++++++++++
 tb/tb_rtc_bcd_timekeeper.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_timekeeper.sv
// BCD time-of-day counter (24-hour HH:MM:SS) advanced by a prescaled tick strobe.
// Provides a validated software time-set path, day-wrap pulse and one-shot alarm compare.
module rtc_bcd_timekeeper #(
  parameter int          TICKS_PER_SEC = 1,
  parameter logic [23:0] RESET_TIME    = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        set_en,
  input  logic [23:0] set_time,
  input  logic        alarm_en,
  input  logic [23:0] alarm_time,
  output logic [23:0] time_bcd,
  output logic        day_wrap,
  output logic        alarm_pulse,
  output logic        set_err
);

  localparam int              PS_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [23:0]     DAY_END = 24'h235959;

  // A time is valid when every digit is decimal and within its field range.
  function automatic logic bcd_time_valid(input logic [23:0] t);
    logic ok;
    ok = (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) && (t[23:16] <= 8'h23) &&
         (t[15:12] <= 4'd5) && (t[11:8]  <= 4'd9) &&
         (t[7:4]   <= 4'd5) && (t[3:0]   <= 4'd9);
    return ok;
  endfunction

  // One-second increment with full carry ripple; 23:59:59 rolls to 00:00:00.
  function automatic logic [23:0] bcd_advance(input logic [23:0] t);
    logic [3:0] ht, hu, mt, mu, st, su;
    {ht, hu, mt, mu, st, su} = t;
    if (su != 4'd9) begin
      su = su + 4'd1;
    end else begin
      su = 4'd0;
      if (st != 4'd5) begin
        st = st + 4'd1;
      end else begin
        st = 4'd0;
        if (mu != 4'd9) begin
          mu = mu + 4'd1;
        end else begin
          mu = 4'd0;
          if (mt != 4'd5) begin
            mt = mt + 4'd1;
          end else begin
            mt = 4'd0;
            if ({ht, hu} == 8'h23) begin
              ht = 4'd0;
              hu = 4'd0;
            end else if (hu == 4'd9) begin
              hu = 4'd0;
              ht = ht + 4'd1;
            end else begin
              hu = hu + 4'd1;
            end
          end
        end
      end
    end
    return {ht, hu, mt, mu, st, su};
  endfunction

  logic [23:0]     time_q, time_d, time_adv;
  logic [PS_W-1:0] presc_q, presc_d;
  logic            wrap_d, alarm_d;
  logic            set_valid, set_ok, alarm_valid;

  assign set_valid   = bcd_time_valid(set_time);
  assign alarm_valid = bcd_time_valid(alarm_time);
  assign set_ok      = set_en && set_valid;
  assign time_adv    = bcd_advance(time_q);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    time_d  = time_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    alarm_d = 1'b0;
    if (set_ok) begin
      // A valid set swallows any coincident tick entirely.
      time_d  = set_time;
      presc_d = '0;
    end else if (tick_in) begin
      if (presc_q == PS_LAST) begin
        presc_d = '0;
        time_d  = time_adv;
        wrap_d  = (time_q == DAY_END);
        alarm_d = alarm_en && alarm_valid && (time_adv == alarm_time);
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q      <= RESET_TIME;
      presc_q     <= '0;
      day_wrap    <= 1'b0;
      alarm_pulse <= 1'b0;
      set_err     <= 1'b0;
    end else begin
      time_q      <= time_d;
      presc_q     <= presc_d;
      day_wrap    <= wrap_d;
      alarm_pulse <= alarm_d;
      set_err     <= set_en && !set_valid;
    end
  end

  assign time_bcd = time_q;

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Directed bench for rtc_bcd_timekeeper: expected results are queued per step and
// popped for comparison one clock later. Two instances cover TICKS_PER_SEC of 1 and 4.
module tb_rtc_bcd_timekeeper;

  typedef struct {
    logic [23:0] t;
    logic        wrap;
    logic        alarm;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_in, set_en, alarm_en;
  logic [23:0] set_time, alarm_time;

  logic [23:0] time1, time4;
  logic        wrap1, alarm1, err1, wrap4, alarm4, err4;

  logic        sel4 = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  string       tags[$];

  always #5 clk = ~clk;

  rtc_bcd_timekeeper #(.TICKS_PER_SEC(1), .RESET_TIME(24'h000000)) dut1 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .set_en(set_en), .set_time(set_time),
    .alarm_en(alarm_en), .alarm_time(alarm_time), .time_bcd(time1), .day_wrap(wrap1),
    .alarm_pulse(alarm1), .set_err(err1)
  );

  rtc_bcd_timekeeper #(.TICKS_PER_SEC(4), .RESET_TIME(24'h000000)) dut4 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .set_en(set_en), .set_time(set_time),
    .alarm_en(alarm_en), .alarm_time(alarm_time), .time_bcd(time4), .day_wrap(wrap4),
    .alarm_pulse(alarm4), .set_err(err4)
  );

  task automatic push_exp(input string tag, input logic [23:0] t, input logic w,
                          input logic a, input logic e);
    exp_t x;
    x.t = t; x.wrap = w; x.alarm = a; x.err = e;
    sb.push_back(x);
    tags.push_back(tag);
  endtask

  task automatic compare_one();
    exp_t        x;
    string       tag;
    logic [23:0] ot;
    logic        ow, oa, oe;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sb.size() > 0) begin
      x   = sb.pop_front();
      tag = tags.pop_front();
      ot  = sel4 ? time4  : time1;
      ow  = sel4 ? wrap4  : wrap1;
      oa  = sel4 ? alarm4 : alarm1;
      oe  = sel4 ? err4   : err1;
      checks++;
      assert (ot === x.t) else begin
        errors++;
        $error("FAIL %s time_bcd: observed %h expected %h", tag, ot, x.t);
      end
      checks++;
      assert (ow === x.wrap) else begin
        errors++;
        $error("FAIL %s day_wrap: observed %b expected %b", tag, ow, x.wrap);
      end
      checks++;
      assert (oa === x.alarm) else begin
        errors++;
        $error("FAIL %s alarm_pulse: observed %b expected %b", tag, oa, x.alarm);
      end
      checks++;
      assert (oe === x.err) else begin
        errors++;
        $error("FAIL %s set_err: observed %b expected %b", tag, oe, x.err);
      end
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare 1 ns after the edge.
  task automatic step(input string tag, input logic tk, input logic se, input logic [23:0] st,
                      input logic [23:0] et, input logic ew, input logic ea, input logic ee);
    tick_in  = tk;
    set_en   = se;
    set_time = st;
    push_exp(tag, et, ew, ea, ee);
    @(posedge clk);
    #1;
    tick_in = 1'b0;
    set_en  = 1'b0;
    compare_one();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    tick_in    = 1'b0;
    set_en     = 1'b0;
    set_time   = 24'h0;
    alarm_en   = 1'b0;
    alarm_time = 24'h0;
    #12;
    push_exp("reset_state", 24'h000000, 1'b0, 1'b0, 1'b0);
    compare_one();
    #10 reset = 1'b0;

    // T1: reset mid-count discards the time immediately
    step("t1_set",  1'b0, 1'b1, 24'h120004, 24'h120004, 1'b0, 1'b0, 1'b0);
    step("t1_tick", 1'b1, 1'b0, 24'h0,      24'h120005, 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    push_exp("t1_async_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    compare_one();
    #2 reset = 1'b0;
    step("t1_after_release", 1'b1, 1'b0, 24'h0, 24'h000001, 1'b0, 1'b0, 1'b0);

    // T2: carry ripple and day wrap
    step("t2_set_095959", 1'b0, 1'b1, 24'h095959, 24'h095959, 1'b0, 1'b0, 1'b0);
    step("t2_ripple",     1'b1, 1'b0, 24'h0,      24'h100000, 1'b0, 1'b0, 1'b0);
    step("t2_set_235959", 1'b0, 1'b1, 24'h235959, 24'h235959, 1'b0, 1'b0, 1'b0);
    step("t2_wrap",       1'b1, 1'b0, 24'h0,      24'h000000, 1'b1, 1'b0, 1'b0);
    step("t2_wrap_once",  1'b0, 1'b0, 24'h0,      24'h000000, 1'b0, 1'b0, 1'b0);
    step("t2_set_000000", 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);

    // T3: a valid set beats a coincident tick
    step("t3_set_and_tick", 1'b1, 1'b1, 24'h123456, 24'h123456, 1'b0, 1'b0, 1'b0);
    step("t3_no_advance",   1'b0, 1'b0, 24'h0,      24'h123456, 1'b0, 1'b0, 1'b0);

    // T4: invalid sets are rejected with a one-cycle error
    step("t4_bad_126a00",   1'b0, 1'b1, 24'h126A00, 24'h123456, 1'b0, 1'b0, 1'b1);
    step("t4_err_once_a",   1'b0, 1'b0, 24'h0,      24'h123456, 1'b0, 1'b0, 1'b0);
    step("t4_bad_240000",   1'b0, 1'b1, 24'h240000, 24'h123456, 1'b0, 1'b0, 1'b1);
    step("t4_err_once_b",   1'b0, 1'b0, 24'h0,      24'h123456, 1'b0, 1'b0, 1'b0);
    step("t4_bad_ss60",     1'b0, 1'b1, 24'h000060, 24'h123456, 1'b0, 1'b0, 1'b1);
    step("t4_bad_with_tick", 1'b1, 1'b1, 24'h240000, 24'h123457, 1'b0, 1'b0, 1'b1);

    // T5: alarm fires only on tick-driven arrival with alarm_en set
    alarm_time = 24'h000100;
    alarm_en   = 1'b1;
    step("t5_set_000059",  1'b0, 1'b1, 24'h000059, 24'h000059, 1'b0, 1'b0, 1'b0);
    step("t5_alarm_hit",   1'b1, 1'b0, 24'h0,      24'h000100, 1'b0, 1'b1, 1'b0);
    step("t5_hold_quiet",  1'b0, 1'b0, 24'h0,      24'h000100, 1'b0, 1'b0, 1'b0);
    alarm_en = 1'b0;
    step("t5_dis_set",     1'b0, 1'b1, 24'h000059, 24'h000059, 1'b0, 1'b0, 1'b0);
    step("t5_dis_tick",    1'b1, 1'b0, 24'h0,      24'h000100, 1'b0, 1'b0, 1'b0);
    alarm_en = 1'b1;
    step("t5_set_to_alarm", 1'b0, 1'b1, 24'h000100, 24'h000100, 1'b0, 1'b0, 1'b0);
    step("t5_past_alarm",   1'b1, 1'b0, 24'h0,      24'h000101, 1'b0, 1'b0, 1'b0);
    alarm_time = 24'h0001A0;
    step("t5_bad_alarm_set", 1'b0, 1'b1, 24'h000159, 24'h000159, 1'b0, 1'b0, 1'b0);
    step("t5_bad_alarm_tick", 1'b1, 1'b0, 24'h0,     24'h000200, 1'b0, 1'b0, 1'b0);
    alarm_en = 1'b0;

    // T6: prescaled instance needs four ticks per second; a valid set restarts the count
    sel4 = 1'b1;
    step("t6_set_000000", 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("t6_tick_hold", 1'b1, 1'b0, 24'h0, 24'h000000, 1'b0, 1'b0, 1'b0);
    step("t6_tick_4th",   1'b1, 1'b0, 24'h0, 24'h000001, 1'b0, 1'b0, 1'b0);
    step("t6_tick_p1",    1'b1, 1'b0, 24'h0, 24'h000001, 1'b0, 1'b0, 1'b0);
    step("t6_idle",       1'b0, 1'b0, 24'h0, 24'h000001, 1'b0, 1'b0, 1'b0);
    step("t6_tick_p2",    1'b1, 1'b0, 24'h0, 24'h000001, 1'b0, 1'b0, 1'b0);
    step("t6_set_000500", 1'b0, 1'b1, 24'h000500, 24'h000500, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("t6_after_set_hold", 1'b1, 1'b0, 24'h0, 24'h000500, 1'b0, 1'b0, 1'b0);
    step("t6_after_set_4th", 1'b1, 1'b0, 24'h0, 24'h000501, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
